// File: rtl/loop_nest_counter.sv
// rtl/loop_nest_counter.sv - three-level (col, row, ch) nested index generator with valid/ready output
//
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   start, abort     job request (IDLE only) and job termination
//   cfg_cols/rows/chs loop bounds, latched on an accepted start (0 is taken as 1)
//   out_ready        consumer accepts the current index tuple
//   out_valid        current tuple is valid (same as busy)
//   col, row, ch     current indices
//   seq              flat element index, counted rather than computed
//   col_last, row_last, last  end-of-dimension flags
//   busy, done       RUN state, one-cycle completion pulse
module loop_nest_counter #(
    parameter int COL_BITS = 5,
    parameter int ROW_BITS = 5,
    parameter int CH_BITS  = 4,
    parameter int SEQ_BITS = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [COL_BITS-1:0] cfg_cols,
    input  logic [ROW_BITS-1:0] cfg_rows,
    input  logic [CH_BITS-1:0]  cfg_chs,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic [CH_BITS-1:0]  ch,
    output logic [SEQ_BITS-1:0] seq,
    output logic                col_last,
    output logic                row_last,
    output logic                last,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [COL_BITS-1:0] cols_q;
    logic [ROW_BITS-1:0] rows_q;
    logic [CH_BITS-1:0]  chs_q;
    logic                run;
    logic                hs;

    assign run       = (state == RUN);
    assign out_valid = run;
    assign busy      = run;
    assign hs        = run && out_ready;

    // Bounds stay latched after a job ends, so the flags are gated with
    // run to keep them low while idle.
    assign col_last = run && (col == cols_q - COL_BITS'(1));
    assign row_last = col_last && (row == rows_q - ROW_BITS'(1));
    assign last     = row_last && (ch == chs_q - CH_BITS'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cols_q <= '0;
            rows_q <= '0;
            chs_q  <= '0;
            col    <= '0;
            row    <= '0;
            ch     <= '0;
            seq    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cols_q <= (cfg_cols == '0) ? COL_BITS'(1) : cfg_cols;
                        rows_q <= (cfg_rows == '0) ? ROW_BITS'(1) : cfg_rows;
                        chs_q  <= (cfg_chs  == '0) ? CH_BITS'(1)  : cfg_chs;
                        col    <= '0;
                        row    <= '0;
                        ch     <= '0;
                        seq    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort beats a simultaneous handshake, even on last.
                        state <= IDLE;
                        col   <= '0;
                        row   <= '0;
                        ch    <= '0;
                        seq   <= '0;
                    end else if (hs) begin
                        if (last) begin
                            state <= IDLE;
                            col   <= '0;
                            row   <= '0;
                            ch    <= '0;
                            seq   <= '0;
                            done  <= 1'b1;
                        end else begin
                            seq <= seq + SEQ_BITS'(1);
                            if (col_last) begin
                                col <= '0;
                                if (row_last) begin
                                    row <= '0;
                                    ch  <= ch + CH_BITS'(1);
                                end else begin
                                    row <= row + ROW_BITS'(1);
                                end
                            end else begin
                                col <= col + COL_BITS'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb/tb_loop_nest_counter.sv - randomized self-checking bench for loop_nest_counter
module tb_loop_nest_counter;

    localparam int CB = 5, RB = 5, HB = 4, SB = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CB-1:0] cfg_cols = '0;
    logic [RB-1:0] cfg_rows = '0;
    logic [HB-1:0] cfg_chs = '0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [CB-1:0] col;
    logic [RB-1:0] row;
    logic [HB-1:0] ch;
    logic [SB-1:0] seq;
    logic          col_last, row_last, last, busy, done;

    loop_nest_counter #(.COL_BITS(CB), .ROW_BITS(RB), .CH_BITS(HB), .SEQ_BITS(SB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_chs(cfg_chs),
        .out_ready(out_ready), .out_valid(out_valid),
        .col(col), .row(row), .ch(ch), .seq(seq),
        .col_last(col_last), .row_last(row_last), .last(last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: job bounds plus count of accepted elements.
    bit m_run = 0;
    bit m_done = 0;
    int k = 0;
    int mc = 1, mr = 1, mh = 1;
    bit cmp_en = 0;

    // Observation counters taken from the DUT on handshake edges.
    int hs_cnt = 0, cl_cnt = 0, rl_cnt = 0, last_cnt = 0, last_seq = -1, done_cnt = 0;

    int ready_mode = 0;  // 0: always 1, 1: random, 2: always 0

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready) begin
            hs_cnt++;
            if (col_last) cl_cnt++;
            if (row_last) rl_cnt++;
            if (last) begin
                last_cnt++;
                last_seq = int'(seq);
            end
        end
        m_done = 0;
        if (!rst) begin
            m_run = 0;
            k = 0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_run = 1;
                k = 0;
                mc = (cfg_cols == 0) ? 1 : int'(cfg_cols);
                mr = (cfg_rows == 0) ? 1 : int'(cfg_rows);
                mh = (cfg_chs == 0) ? 1 : int'(cfg_chs);
            end
        end else if (abort) begin
            m_run = 0;
        end else if (out_ready) begin
            if (k == mc * mr * mh - 1) begin
                m_run = 0;
                m_done = 1;
            end else begin
                k++;
            end
        end
    end

    always @(negedge clk) begin
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b0;
    end

    // Per-cycle compare of the whole output bundle against the model.
    always @(negedge clk) begin
        logic [CB+RB+HB+SB+5:0] act, exp;
        int ec, er, eh;
        logic ecl, erl, el;
        if (cmp_en) begin
            if (done) done_cnt++;
            ec = 0; er = 0; eh = 0; ecl = 0; erl = 0; el = 0;
            if (m_run) begin
                ec  = k % mc;
                er  = (k / mc) % mr;
                eh  = k / (mc * mr);
                ecl = (ec == mc - 1);
                erl = ecl && (er == mr - 1);
                el  = erl && (eh == mh - 1);
            end
            exp = {m_run, CB'(ec), RB'(er), HB'(eh), SB'(m_run ? k % (1 << SB) : 0),
                   ecl, erl, el, m_run, m_done};
            act = {out_valid, col, row, ch, seq, col_last, row_last, last, busy, done};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL cycle_bundle t=%0t actual=%h required=%h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        hs_cnt = 0; cl_cnt = 0; rl_cnt = 0; last_cnt = 0; last_seq = -1; done_cnt = 0;
    endtask

    task automatic launch(input int c, input int r, input int h);
        @(negedge clk);
        cfg_cols = CB'(c); cfg_rows = RB'(r); cfg_chs = HB'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(done === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_seq(input string name, input int v);
        int n = 0;
        while (!(busy === 1'b1 && int'(seq) == v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(busy === 1'b1 && int'(seq) == v)) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("reset_outputs", int'({out_valid, col, row, ch, seq, col_last, row_last, last, busy, done}), 0);
        rst = 1'b1;

        // Unstalled 3x2x2 run.
        clear_obs();
        launch(3, 2, 2);
        wait_done("t1", 40);
        @(negedge clk);
        chk("t1_handshakes", hs_cnt, 12);
        chk("t1_col_last", cl_cnt, 4);
        chk("t1_row_last", rl_cnt, 2);
        chk("t1_last", last_cnt, 1);
        chk("t1_last_seq", last_seq, 11);
        chk("t1_done_pulses", done_cnt, 1);

        // Same job with random stalls.
        clear_obs();
        ready_mode = 1;
        launch(3, 2, 2);
        wait_done("t2", 400);
        @(negedge clk);
        ready_mode = 0;
        chk("t2_handshakes", hs_cnt, 12);
        chk("t2_col_last", cl_cnt, 4);
        chk("t2_last_seq", last_seq, 11);
        chk("t2_done_pulses", done_cnt, 1);

        // Degenerate single-element volumes.
        for (int v = 0; v < 2; v++) begin
            clear_obs();
            launch(v, v, v);
            wait_done("t3", 10);
            @(negedge clk);
            chk("t3_handshakes", hs_cnt, 1);
            chk("t3_last", last_cnt, 1);
            chk("t3_row_last", rl_cnt, 1);
            chk("t3_last_seq", last_seq, 0);
        end

        // Abort at seq 5, with the consumer ready and then stalled.
        for (int m = 0; m < 2; m++) begin
            clear_obs();
            launch(3, 2, 2);
            wait_seq("t4", 5);
            ready_mode = (m == 0) ? 0 : 2;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            ready_mode = 0;
            chk("t4_valid_after_abort", int'(out_valid), 0);
            repeat (4) @(negedge clk);
            chk("t4_no_done", done_cnt, 0);
            launch(3, 2, 2);
            chk("t4_restart_seq", int'(seq), 0);
            chk("t4_restart_valid", int'(out_valid), 1);
            wait_done("t4r", 40);
            @(negedge clk);
        end

        // start with new bounds mid-job is ignored; start in the done cycle is taken.
        clear_obs();
        launch(3, 2, 2);
        wait_seq("t5", 3);
        cfg_cols = 4; cfg_rows = 4; cfg_chs = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 40);
        chk("t5_first_job_len", hs_cnt, 12);
        cfg_cols = 2; cfg_rows = 2; cfg_chs = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_next_job_valid", int'(out_valid), 1);
        wait_done("t5b", 40);
        @(negedge clk);
        chk("t5_total_handshakes", hs_cnt, 16);
        chk("t5_done_pulses", done_cnt, 2);

        // Reset mid-job.
        clear_obs();
        launch(3, 2, 2);
        wait_seq("t6", 7);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t6_outputs_zero", int'({out_valid, col, row, ch, seq, col_last, row_last, last, busy, done}), 0);
        repeat (5) @(negedge clk);
        chk("t6_stays_idle", int'(busy), 0);
        chk("t6_no_done", done_cnt, 0);

        // Random small jobs under random stalls.
        ready_mode = 1;
        for (int j = 0; j < 6; j++) begin
            launch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            wait_done("rand", 2000);
            @(negedge clk);
        end
        ready_mode = 0;

        // Full-bound volume.
        clear_obs();
        launch(31, 31, 15);
        wait_done("full", 20000);
        @(negedge clk);
        chk("full_handshakes", hs_cnt, 14415);
        chk("full_last_seq", last_seq, 14414);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
